// File: rtl/servo_pwm_pkg.sv
// Shared timing constants and FSM encoding for the servo PWM generator/decoder pair.
package servo_pwm_pkg;

  localparam int unsigned CyclesPerMs = 50000;
  localparam int unsigned Duty1       = 50000;
  localparam int unsigned Duty2       = 125000;
  localparam int unsigned Period      = 1000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwm_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer for the asynchronous PWM line plus a previous-sample
// flop, giving a clean level and single-cycle rise/fall indications.
module pwm_edge_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic PwmIn,
  output logic Level,
  output logic Rise,
  output logic Fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Next-state of the synchronizer chain and history flop.
  always_comb begin
    meta_d = PwmIn;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchronizer and history registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Edges are derived from flop outputs only, so they are glitch-free.
  assign Level = sync_q;
  assign Rise  = sync_q & ~prev_q;
  assign Fall  = ~sync_q & prev_q;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: measures high time and rise-to-rise period, validates
// each frame and reports width, decoded position and loss of signal.
module servo_pwm_decoder
  import servo_pwm_pkg::*;
#(
  parameter int unsigned MinWidth      = 40000,
  parameter int unsigned MaxWidth      = 135000,
  parameter int unsigned Threshold     = 87500,
  parameter int unsigned PeriodMin     = 900000,
  parameter int unsigned PeriodMax     = 1100000,
  parameter int unsigned TimeoutCycles = 2000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PwmIn,
  output logic [31:0] PulseWidth,
  output logic        PosState,
  output logic        Valid,
  output logic        FrameErr,
  output logic        SignalLost
);

  logic level, rise, fall;

  pwm_edge_sync u_edge_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .PwmIn (PwmIn),
    .Level (level),
    .Rise  (rise),
    .Fall  (fall)
  );

  pwm_state_e  state_q, state_d;
  logic [31:0] high_cnt_q, high_cnt_d;
  logic [31:0] period_cnt_q, period_cnt_d;
  logic [31:0] idle_cnt_q, idle_cnt_d;
  logic [31:0] width_q, width_d;
  logic [31:0] pulse_width_q, pulse_width_d;
  logic        pos_q, pos_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;
  logic        lost_q, lost_d;

  logic        edge_seen, timeout, width_ok, period_ok;

  // Counters, frame FSM, range checks and output next-state.
  always_comb begin
    edge_seen = rise | fall;
    // An edge in the timeout cycle clears the idle counter and wins.
    timeout   = !edge_seen && (idle_cnt_q >= TimeoutCycles);
    width_ok  = (width_q >= MinWidth) && (width_q <= MaxWidth);
    period_ok = (period_cnt_q >= PeriodMin) && (period_cnt_q <= PeriodMax);

    if (rise) begin
      high_cnt_d = 32'd1;
    end else if (state_q == HIGH && level) begin
      high_cnt_d = sat_inc(high_cnt_q);
    end else begin
      high_cnt_d = high_cnt_q;
    end
    period_cnt_d = rise ? 32'd1 : sat_inc(period_cnt_q);
    idle_cnt_d   = edge_seen ? '0 : sat_inc(idle_cnt_q);

    state_d       = state_q;
    width_d       = width_q;
    pulse_width_d = pulse_width_q;
    pos_d         = pos_q;
    valid_d       = 1'b0;
    frame_err_d   = 1'b0;
    lost_d        = lost_q;

    if (timeout) begin
      state_d = IDLE;
      lost_d  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (rise) state_d = HIGH;
        HIGH: if (fall) begin
          state_d = LOW;
          width_d = high_cnt_q;
        end
        LOW: if (rise) begin
          // This rise closes the current frame and opens the next one.
          state_d = HIGH;
          if (width_ok && period_ok) begin
            valid_d       = 1'b1;
            pulse_width_d = width_q;
            pos_d         = (width_q <= Threshold);
            lost_d        = 1'b0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, counter and output registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      high_cnt_q    <= '0;
      period_cnt_q  <= '0;
      idle_cnt_q    <= '0;
      width_q       <= '0;
      pulse_width_q <= '0;
      pos_q         <= 1'b0;
      valid_q       <= 1'b0;
      frame_err_q   <= 1'b0;
      lost_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      high_cnt_q    <= high_cnt_d;
      period_cnt_q  <= period_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      width_q       <= width_d;
      pulse_width_q <= pulse_width_d;
      pos_q         <= pos_d;
      valid_q       <= valid_d;
      frame_err_q   <= frame_err_d;
      lost_q        <= lost_d;
    end
  end

  assign PulseWidth = pulse_width_q;
  assign PosState   = pos_q;
  assign Valid      = valid_q;
  assign FrameErr   = frame_err_q;
  assign SignalLost = lost_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Randomized and directed bench for servo_pwm_decoder with scaled timing.
// The reference model works on the driven waveform's edge times only.
module tb_servo_pwm_decoder;

  localparam int MIN_W   = 40;
  localparam int MAX_W   = 135;
  localparam int THR     = 87;
  localparam int PER_MIN = 900;
  localparam int PER_MAX = 1100;
  localparam int TMO     = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwm = 1'b0;
  logic [31:0] pulse_width;
  logic        pos_state, valid, frame_err, signal_lost;

  servo_pwm_decoder #(
    .MinWidth      (MIN_W),
    .MaxWidth      (MAX_W),
    .Threshold     (THR),
    .PeriodMin     (PER_MIN),
    .PeriodMax     (PER_MAX),
    .TimeoutCycles (TMO)
  ) dut (
    .Clk        (clk),
    .Reset      (rst),
    .PwmIn      (pwm),
    .PulseWidth (pulse_width),
    .PosState   (pos_state),
    .Valid      (valid),
    .FrameErr   (frame_err),
    .SignalLost (signal_lost)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: frames are judged from the times the bench itself
  // toggled PwmIn; outcomes appear 3 cycles after the closing rise.
  typedef struct {
    int cyc;
    bit ok;
    int w;
    bit pos;
  } exp_t;

  exp_t exp_q[$];
  bit   m_open;
  int   m_rise;
  int   m_width;
  int   m_last_edge;
  bit   m_lost;
  int   m_pw;
  bit   m_pos;

  function automatic void model_edge(input bit is_rise, input int c);
    exp_t e;
    int   per;
    if (c - m_last_edge > TMO) begin
      m_open = 1'b0;
      m_lost = 1'b1;
    end
    m_last_edge = c;
    if (is_rise) begin
      if (m_open && m_width >= 0) begin
        per   = c - m_rise;
        e.cyc = c + 3;
        e.ok  = (m_width >= MIN_W) && (m_width <= MAX_W) &&
                (per >= PER_MIN) && (per <= PER_MAX);
        e.w   = m_width;
        e.pos = (m_width <= THR);
        exp_q.push_back(e);
        if (e.ok) begin
          m_pw   = e.w;
          m_pos  = e.pos;
          m_lost = 1'b0;
        end
      end
      m_open  = 1'b1;
      m_rise  = c;
      m_width = -1;
    end else if (m_open) begin
      m_width = c - m_rise;
    end
  endfunction

  function automatic void model_reset(input int c);
    m_open      = 1'b0;
    m_width     = -1;
    m_lost      = 1'b1;
    m_pw        = 0;
    m_pos       = 1'b0;
    m_last_edge = c;
    while (exp_q.size() != 0 && exp_q[$].cyc >= c) void'(exp_q.pop_back());
  endfunction

  // Strobe monitor: any cycle where a strobe is seen or expected is compared.
  always @(negedge clk) begin
    bit ev, ee, hit;
    ev  = 1'b0;
    ee  = 1'b0;
    hit = (exp_q.size() != 0) && (exp_q[0].cyc == cyc);
    if (hit) begin
      ev = exp_q[0].ok;
      ee = !exp_q[0].ok;
    end
    if (valid || frame_err || hit) begin
      check_val("valid", valid, ev);
      check_val("frame_err", frame_err, ee);
      if (ev) begin
        check_val("pulse_width", pulse_width, exp_q[0].w);
        check_val("pos_state", pos_state, exp_q[0].pos);
        check_val("lost_on_valid", signal_lost, 0);
      end
      if (hit) void'(exp_q.pop_front());
    end
  end

  task automatic check_steady(input string tag);
    check_val({tag, "_width"}, pulse_width, m_pw);
    check_val({tag, "_pos"}, pos_state, m_pos);
    check_val({tag, "_lost"}, signal_lost, m_lost);
  endtask

  task automatic send_frame(input int hi, input int per);
    pwm = 1'b1;
    model_edge(1'b1, cyc);
    repeat (hi) @(negedge clk);
    pwm = 1'b0;
    model_edge(1'b0, cyc);
    repeat (per - hi) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset(cyc);
    check_val("rst_width", pulse_width, 0);
    check_val("rst_pos", pos_state, 0);
    check_val("rst_valid", valid, 0);
    check_val("rst_frame_err", frame_err, 0);
    check_val("rst_lost", signal_lost, 1);
    if (pwm) model_edge(1'b1, cyc);
  endtask

  int bnd_hi  [10] = '{40, 135, 39, 136, 87, 88, 60, 60, 60, 60};
  int bnd_per [10] = '{900, 1100, 1000, 1000, 1000, 1000, 899, 1101, 900, 1100};

  initial begin
    int t0, hi, per, sel;
    repeat (3) @(negedge clk);
    pulse_reset();
    repeat (20) @(negedge clk);

    // Basic loop: short pulses, first result after the second rise.
    for (int i = 0; i < 3; i++) send_frame(51, 1001);
    check_steady("short");

    // Long pulses, then switching between short and long.
    for (int i = 0; i < 3; i++) send_frame(126, 1001);
    check_steady("long");
    send_frame(51, 1001);
    send_frame(126, 1001);
    send_frame(51, 1001);
    check_steady("toggle");

    // Width out of range on both sides.
    send_frame(20, 1001);
    send_frame(150, 1001);
    send_frame(126, 1001);
    check_steady("bad_width");

    // Period out of range on both sides.
    send_frame(51, 500);
    send_frame(51, 1500);
    send_frame(51, 1001);
    check_steady("bad_period");

    // Exact range limits and decode threshold.
    for (int i = 0; i < 10; i++) begin
      send_frame(bnd_hi[i], bnd_per[i]);
      check_steady("boundary");
    end

    // Random mix of good and bad frames.
    for (int i = 0; i < 16; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)      hi = $urandom_range(MIN_W, MAX_W);
      else if (sel < 8) hi = $urandom_range(10, MIN_W - 1);
      else              hi = $urandom_range(MAX_W + 1, 200);
      if ($urandom_range(0, 3) == 0)
        per = ($urandom_range(0, 1) == 1) ? $urandom_range(600, PER_MIN - 1)
                                          : $urandom_range(PER_MAX + 1, 1400);
      else
        per = $urandom_range(PER_MIN, PER_MAX);
      send_frame(hi, per);
      check_steady("random");
    end

    // Stuck high: signal lost, then recovery after two rises.
    send_frame(51, 1001);
    send_frame(51, 1001);
    pwm = 1'b1;
    model_edge(1'b1, cyc);
    t0 = cyc;
    repeat (TMO - 10) @(negedge clk);
    check_val("lost_before_timeout", signal_lost, 0);
    repeat (20) @(negedge clk);
    check_val("lost_stuck_high", signal_lost, 1);
    repeat (2500 - (cyc - t0)) @(negedge clk);
    pwm = 1'b0;
    model_edge(1'b0, cyc);
    repeat (950) @(negedge clk);
    send_frame(51, 1001);
    check_val("lost_after_first_rise", signal_lost, 1);
    send_frame(126, 1001);
    check_steady("recovered");

    // Reset in the middle of a high phase.
    send_frame(51, 1001);
    pwm = 1'b1;
    model_edge(1'b1, cyc);
    repeat (20) @(negedge clk);
    pulse_reset();
    repeat (30) @(negedge clk);
    pwm = 1'b0;
    model_edge(1'b0, cyc);
    repeat (950) @(negedge clk);
    for (int i = 0; i < 3; i++) send_frame(126, 1001);
    check_steady("after_reset");

    // Close the last frame, drain, then stuck low.
    pwm = 1'b1;
    model_edge(1'b1, cyc);
    repeat (8) @(negedge clk);
    check_val("queue_drained", exp_q.size(), 0);
    check_steady("final");
    pwm = 1'b0;
    model_edge(1'b0, cyc);
    repeat (2500) @(negedge clk);
    check_val("lost_stuck_low", signal_lost, 1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
